// File: rtl/lock_ctrl.sv
// rtl/lock_ctrl.sv - keypad door lock: 4-digit code entry, timed open/fail, password change
// Optional lockout after MAX_TRIES consecutive failures when LOCK_CTRL_LOCKOUT_EN is defined.
module lock_ctrl #(
  parameter logic [15:0] PASSWORD    = 16'h1234,
  parameter logic [23:0] OPEN_CYCLES = 24'd1000,
  parameter logic [23:0] FAIL_CYCLES = 24'd500,
  parameter int          MAX_TRIES   = 3,
  parameter logic [23:0] LOCK_CYCLES = 24'd5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_flag,
  input  logic [3:0] key_value,
  output logic       unlocked,
  output logic       fail,
  output logic       locked_out,
  output logic [2:0] digit_cnt
);

`ifdef LOCK_CTRL_LOCKOUT_EN
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, SETPW, FAIL, LOCKOUT} state_t;
`else
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, SETPW, FAIL} state_t;
`endif

  localparam logic [7:0] MAX_ERR = 8'(MAX_TRIES);

  state_t      state;
  logic [15:0] password;
  logic [15:0] buffer;
  logic [23:0] timer;
  logic [7:0]  err_cnt;
  logic        code_ok;

  // key_flag gates every decode so key_value is never looked at when idle
  logic is_digit, is_clr, is_ent, buf_full;
  assign is_digit = key_flag && (key_value <= 4'd9);
  assign is_clr   = key_flag && (key_value == 4'd10);
  assign is_ent   = key_flag && (key_value == 4'd11);
  assign buf_full = (digit_cnt == 3'd4);

`ifndef LOCK_CTRL_LOCKOUT_EN
  logic unused_lock_cycles;
  assign unused_lock_cycles = ^LOCK_CYCLES;
  assign locked_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      password  <= PASSWORD;
      buffer    <= 16'h0;
      digit_cnt <= 3'd0;
      err_cnt   <= 8'd0;
      timer     <= 24'd0;
      code_ok   <= 1'b0;
      unlocked  <= 1'b0;
      fail      <= 1'b0;
`ifdef LOCK_CTRL_LOCKOUT_EN
      locked_out <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (is_digit) begin
            state     <= ENTRY;
            buffer    <= {12'h0, key_value};
            digit_cnt <= 3'd1;
          end
        end

        ENTRY: begin
          if (is_digit) begin
            if (!buf_full) begin
              buffer    <= {buffer[11:0], key_value};
              digit_cnt <= digit_cnt + 3'd1;
            end
          end else if (is_clr) begin
            state     <= IDLE;
            buffer    <= 16'h0;
            digit_cnt <= 3'd0;
          end else if (is_ent) begin
            // buffer is cleared on exit, so the comparison is captured here for CHECK
            code_ok   <= buf_full && (buffer == password);
            buffer    <= 16'h0;
            digit_cnt <= 3'd0;
            if (buf_full) begin
              state <= CHECK;
            end else begin
              state   <= FAIL;
              fail    <= 1'b1;
              timer   <= FAIL_CYCLES - 24'd1;
              err_cnt <= (err_cnt == MAX_ERR) ? err_cnt : err_cnt + 8'd1;
            end
          end
        end

        CHECK: begin
          if (code_ok) begin
            state    <= OPEN;
            unlocked <= 1'b1;
            timer    <= OPEN_CYCLES - 24'd1;
            err_cnt  <= 8'd0;
          end else begin
            state   <= FAIL;
            fail    <= 1'b1;
            timer   <= FAIL_CYCLES - 24'd1;
            err_cnt <= (err_cnt == MAX_ERR) ? err_cnt : err_cnt + 8'd1;
          end
        end

        OPEN: begin
          if (timer == 24'd0) begin
            state    <= IDLE;
            unlocked <= 1'b0;
          end else begin
            timer <= timer - 24'd1;
            if (is_clr) begin
              state    <= IDLE;
              unlocked <= 1'b0;
            end else if (is_ent) begin
              state <= SETPW;
            end
          end
        end

        SETPW: begin
          // timer is left untouched here; every exit goes back to IDLE anyway
          if (is_digit) begin
            if (!buf_full) begin
              buffer    <= {buffer[11:0], key_value};
              digit_cnt <= digit_cnt + 3'd1;
            end
          end else if (is_clr || is_ent) begin
            if (is_ent && buf_full) password <= buffer;
            state     <= IDLE;
            unlocked  <= 1'b0;
            buffer    <= 16'h0;
            digit_cnt <= 3'd0;
          end
        end

        FAIL: begin
          if (timer == 24'd0) begin
            fail  <= 1'b0;
            state <= IDLE;
`ifdef LOCK_CTRL_LOCKOUT_EN
            if (err_cnt == MAX_ERR) begin
              state      <= LOCKOUT;
              locked_out <= 1'b1;
              timer      <= LOCK_CYCLES - 24'd1;
            end
`endif
          end else begin
            timer <= timer - 24'd1;
          end
        end

`ifdef LOCK_CTRL_LOCKOUT_EN
        LOCKOUT: begin
          if (timer == 24'd0) begin
            state      <= IDLE;
            locked_out <= 1'b0;
            err_cnt    <= 8'd0;
          end else begin
            timer <= timer - 24'd1;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_ctrl.sv
// tb/tb_lock_ctrl.sv - randomized bench for lock_ctrl against a queue-based reference model
// Lockout scenarios run only when LOCK_CTRL_LOCKOUT_EN is defined.
module tb_lock_ctrl;
  localparam int OPEN_C = 100;
  localparam int FAIL_C = 50;
  localparam int LOCK_C = 200;
  localparam int MAXT   = 3;
  localparam logic [15:0] PW = 16'h1234;
`ifdef LOCK_CTRL_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_flag = 1'b0;
  logic [3:0] key_value = 4'd0;
  logic       unlocked, fail, locked_out;
  logic [2:0] digit_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  lock_ctrl #(
    .PASSWORD(PW), .OPEN_CYCLES(24'd100), .FAIL_CYCLES(24'd50),
    .MAX_TRIES(MAXT), .LOCK_CYCLES(24'd200)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_flag(key_flag), .key_value(key_value),
    .unlocked(unlocked), .fail(fail), .locked_out(locked_out), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entry buffer as a queue, timed states as "cycles remaining".
  int m_buf[$];
  int m_pw[4];
  int m_open, m_fail, m_lock, m_errs;
  bit m_setpw, m_check, m_ok;

  function automatic void m_reset();
    m_buf.delete();
    for (int i = 0; i < 4; i++) m_pw[i] = int'((PW >> (12 - 4 * i)) & 16'hF);
    m_open = 0; m_fail = 0; m_lock = 0; m_errs = 0;
    m_setpw = 0; m_check = 0; m_ok = 0;
  endfunction

  function automatic void m_fail_start();
    m_fail = FAIL_C;
    if (m_errs < MAXT) m_errs++;
  endfunction

  function automatic bit m_buf_matches();
    for (int i = 0; i < 4; i++) if (m_buf[i] != m_pw[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_step(input bit kf, input int kv);
    int key;
    key = kf ? kv : 15;
    if (m_check) begin
      m_check = 0;
      if (m_ok) begin m_open = OPEN_C; m_errs = 0; end
      else m_fail_start();
    end else if (m_fail > 0) begin
      m_fail--;
      if (m_fail == 0 && LOCK_EN && m_errs == MAXT) m_lock = LOCK_C;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_errs = 0;
    end else if (m_setpw) begin
      if (key <= 9) begin
        if (m_buf.size() < 4) m_buf.push_back(key);
      end else if (key == 10 || key == 11) begin
        if (key == 11 && m_buf.size() == 4) for (int i = 0; i < 4; i++) m_pw[i] = m_buf[i];
        m_buf.delete(); m_setpw = 0; m_open = 0;
      end
    end else if (m_open > 0) begin
      m_open--;
      if (m_open > 0) begin
        if (key == 10) m_open = 0;
        else if (key == 11) m_setpw = 1;
      end
    end else begin
      if (key <= 9) begin
        if (m_buf.size() < 4) m_buf.push_back(key);
      end else if (key == 10) begin
        m_buf.delete();
      end else if (key == 11 && m_buf.size() > 0) begin
        if (m_buf.size() == 4) begin m_check = 1; m_ok = m_buf_matches(); end
        else m_fail_start();
        m_buf.delete();
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step(key_flag, int'(key_value));
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_unlocked", int'(unlocked), int'((m_open > 0) || m_setpw));
      check("cmp_fail", int'(fail), int'(m_fail > 0));
      check("cmp_locked_out", int'(locked_out), int'(m_lock > 0));
      check("cmp_digit_cnt", int'(digit_cnt), m_buf.size());
    end
  end

  task automatic press(input int k);
    key_flag = 1'b1;
    key_value = 4'(k);
    @(posedge clk); #1;
    key_flag = 1'b0;
    key_value = 4'($urandom);
  endtask

  task automatic press_code(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d); press(11);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; key_value = 4'($urandom); end
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? unlocked : (sel == 1) ? fail : locked_out;
  endfunction

  task automatic count_high(input int sel, output int cnt);
    cnt = 0;
    while (cnt < 1000 && sig(sel)) begin cnt++; @(posedge clk); #1; end
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((unlocked || fail || locked_out) && n < 1000) begin @(posedge clk); #1; n++; end
    check("wait_quiet_timeout", int'(n < 1000), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int r;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_unlocked", int'(unlocked), 0);
    check("rst_fail", int'(fail), 0);
    check("rst_locked_out", int'(locked_out), 0);
    check("rst_digit_cnt", int'(digit_cnt), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(2);

    // correct code opens two cycles after '#', for exactly OPEN_C cycles
    press_code(1, 2, 3, 4);
    check("unlock_early", int'(unlocked), 0);
    @(posedge clk); #1;
    check("unlock_2cyc", int'(unlocked), 1);
    count_high(0, cnt);
    check("open_len", cnt, 100);
    idle(3);

    // wrong code and short entry
    press_code(1, 2, 3, 5);
    @(posedge clk); #1;
    check("wrong_fail", int'(fail), 1);
    count_high(1, cnt);
    check("fail_len", cnt, 50);
    press(1); press(2); press(11);
    check("short_fail", int'(fail), 1);
    wait_quiet();

    // clear, saturation, '*' closes the door
    press(1); press(2); press(10);
    check("clr_cnt", int'(digit_cnt), 0);
    press(1); press(2); press(3); press(4); press(5);
    check("sat_cnt", int'(digit_cnt), 4);
    press(11);
    @(posedge clk); #1;
    check("sat_open", int'(unlocked), 1);
    press(10);
    check("star_close", int'(unlocked), 0);
    idle(2);

    // password change
    press_code(1, 2, 3, 4);
    @(posedge clk); #1;
    press(11);
    check("setpw_unl", int'(unlocked), 1);
    press_code(9, 8, 7, 6);
    check("setpw_exit", int'(unlocked), 0);
    press_code(1, 2, 3, 4);
    @(posedge clk); #1;
    check("old_pw_fail", int'(fail), 1);
    wait_quiet();
    press_code(9, 8, 7, 6);
    @(posedge clk); #1;
    check("new_pw_open", int'(unlocked), 1);
    press(10);
    do_reset();
    press_code(1, 2, 3, 4);
    @(posedge clk); #1;
    check("reset_pw_open", int'(unlocked), 1);
    press(10);
    idle(2);

`ifdef LOCK_CTRL_LOCKOUT_EN
    for (int t = 0; t < 3; t++) begin
      press_code(5, 5, 5, 5);
      @(posedge clk); #1;
      count_high(1, cnt);
    end
    check("lock_on", int'(locked_out), 1);
    press_code(1, 2, 3, 4);
    count_high(2, cnt);
    check("lock_len", cnt, 195);
    check("lock_unl", int'(unlocked), 0);
    press_code(1, 2, 3, 4);
    @(posedge clk); #1;
    check("post_lock_open", int'(unlocked), 1);
    press(10);
    idle(2);
`endif

    // key_value garbage with key_flag low must do nothing
    for (int i = 0; i < 1000; i++) begin
      key_value = (i % 2 == 0) ? 4'bxxxx : 4'($urandom);
      @(posedge clk); #1;
    end
    check("x_unlocked", int'(unlocked), 0);
    check("x_fail", int'(fail), 0);
    check("x_digit_cnt", int'(digit_cnt), 0);

    // randomized traffic
    for (int it = 0; it < 1500; it++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) do_reset();
      else if (r < 60) press_code(m_pw[0], m_pw[1], m_pw[2], m_pw[3]);
      else if (r < 75) press(11);
      else if (r < 85) press(10);
      else press(int'($urandom_range(0, 15)));
      idle(int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
